// File: rtl/cic_interp_if.sv
// Sample-stream bundle between the upsampler chain and the CIC interpolator.
// The master side drives enable and low-rate samples; the slave side returns strobe and output.
interface cic_interp_if #(
    parameter int unsigned DATA_WIDTH_I = 16,
    parameter int unsigned DATA_WIDTH_O = 12
);
    logic                    en;
    logic [DATA_WIDTH_I-1:0] data_in;
    logic                    data_clk;
    logic [DATA_WIDTH_O-1:0] data_out;
    logic                    data_valid;

    modport master (
        output en,
        output data_in,
        input  data_clk,
        input  data_out,
        input  data_valid
    );

    modport slave (
        input  en,
        input  data_in,
        output data_clk,
        output data_out,
        output data_valid
    );
endinterface

// File: rtl/cic_interp.sv
// Hogenauer CIC interpolator: N combs at the low rate, zero-stuffing, N integrators at the high rate.
// All arithmetic wraps mod 2^REGISTER_WIDTH; the output is the truncated MSB slice of the last integrator.
module cic_interp #(
    parameter int unsigned DATA_WIDTH_I        = 16,
    parameter int unsigned DATA_WIDTH_O        = 12,
    parameter int unsigned REGISTER_WIDTH      = 40,
    parameter int unsigned NUM_STAGES          = 3,
    parameter int unsigned INTERPOLATION_RATIO = 1625
) (
    input logic         clk,
    input logic         arst_n,
    cic_interp_if.slave bus
);
    localparam int unsigned RW = REGISTER_WIDTH;
    localparam int unsigned PW = (INTERPOLATION_RATIO > 1) ? $clog2(INTERPOLATION_RATIO) : 1;
    localparam logic [PW-1:0] PHASE_LAST = PW'(INTERPOLATION_RATIO - 1);

    logic [PW-1:0] phase_q, phase_d;
    logic [RW-1:0] dly_q   [NUM_STAGES];
    logic [RW-1:0] dly_d   [NUM_STAGES];
    logic [RW-1:0] integ_q [NUM_STAGES];
    logic [RW-1:0] integ_d [NUM_STAGES];
    logic [RW-1:0] comb_q, comb_d;
    logic          valid_q;
    logic          phase_zero;
    logic          capture;
    logic [RW-1:0] u;

    always_comb begin
        phase_zero = (phase_q == '0);
        capture    = bus.en & phase_zero;
    end

    always_comb begin
        phase_d = phase_q;
        if (bus.en) begin
            phase_d = (phase_q == PHASE_LAST) ? '0 : phase_q + 1'b1;
        end
    end

    // Comb cascade folded into one running value; each delay takes the stage's input.
    always_comb begin
        logic [RW-1:0] c_acc;
        c_acc = RW'($signed(bus.data_in));
        for (int unsigned k = 0; k < NUM_STAGES; k++) begin
            dly_d[k] = capture ? c_acc : dly_q[k];
            c_acc    = c_acc - dly_q[k];
        end
        comb_d = capture ? c_acc : comb_q;
    end

    // Zero-stuffing uses the pre-edge comb_q, so a capture enters the integrators one low-rate period later.
    always_comb begin
        u = phase_zero ? comb_q : '0;
        for (int unsigned k = 0; k < NUM_STAGES; k++) begin
            integ_d[k] = integ_q[k];
        end
        if (bus.en) begin
            integ_d[0] = integ_q[0] + u;
            for (int unsigned k = 1; k < NUM_STAGES; k++) begin
                integ_d[k] = integ_q[k] + integ_q[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            phase_q <= '0;
            comb_q  <= '0;
            valid_q <= 1'b0;
            for (int unsigned k = 0; k < NUM_STAGES; k++) begin
                dly_q[k]   <= '0;
                integ_q[k] <= '0;
            end
        end else begin
            phase_q <= phase_d;
            comb_q  <= comb_d;
            valid_q <= bus.en;
            for (int unsigned k = 0; k < NUM_STAGES; k++) begin
                dly_q[k]   <= dly_d[k];
                integ_q[k] <= integ_d[k];
            end
        end
    end

    assign bus.data_clk   = capture;
    assign bus.data_out   = integ_q[NUM_STAGES-1][RW-1 -: DATA_WIDTH_O];
    assign bus.data_valid = valid_q;
endmodule

// File: tb/tb_cic_interp.sv
// Bench for cic_interp: a small config (R=4, N=3, 24-bit) and the default config run side by side.
// Expected outputs come from convolving the zero-stuffed input with the boxcar impulse response.
module tb_cic_interp;
    localparam int RA = 4;
    localparam int NA = 3;
    localparam int RB = 1625;
    localparam int NB = 3;
    localparam int LB = NB * (RB - 1) + 1;
    localparam int B_SAMPLES = 24;

    logic clk = 1'b0;
    logic arst_a_n = 1'b1;
    logic arst_b_n = 1'b1;
    always #5 clk = ~clk;

    cic_interp_if #(.DATA_WIDTH_I(16), .DATA_WIDTH_O(24)) a_if ();
    cic_interp_if #(.DATA_WIDTH_I(16), .DATA_WIDTH_O(12)) b_if ();

    cic_interp #(
        .DATA_WIDTH_I(16),
        .DATA_WIDTH_O(24),
        .REGISTER_WIDTH(24),
        .NUM_STAGES(NA),
        .INTERPOLATION_RATIO(RA)
    ) dut_a (
        .clk(clk),
        .arst_n(arst_a_n),
        .bus(a_if)
    );

    cic_interp dut_b (
        .clk(clk),
        .arst_n(arst_b_n),
        .bus(b_if)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- small config state and model ----------------
    int     ha [10] = '{1, 3, 6, 10, 12, 12, 10, 6, 3, 1};
    longint xa [$];
    longint qa [$];
    int     ka = 0;
    longint last_a = 0;
    longint obs_last_a = 0;
    longint sum_a = 0;
    int     first_nz_a = -1;
    int     vidx_a = 0;
    bit     en_last_a = 1'b0;
    bit     mon_a = 1'b0;

    function automatic longint model_a(input int k);
        longint acc;
        logic [63:0] t;
        logic signed [23:0] s;
        acc = 0;
        for (int j = 0; j < xa.size(); j++) begin
            int idx;
            idx = k - (j * RA + RA + NA - 1);
            if (idx >= 0 && idx < 10) acc += xa[j] * ha[idx];
        end
        t = acc;
        s = t[23:0];
        return longint'(s);
    endfunction

    always @(negedge clk) begin
        if (mon_a && arst_a_n) begin
            longint got_v;
            got_v = longint'($signed(a_if.data_out));
            check("a_valid", longint'(a_if.data_valid), longint'(en_last_a));
            if (en_last_a) begin
                if (qa.size() == 0) begin
                    check("a_sb_depth", qa.size(), 1);
                end else begin
                    check("a_out", got_v, qa.pop_front());
                    sum_a += got_v;
                    obs_last_a = got_v;
                    if (first_nz_a < 0 && got_v != 0) first_nz_a = vidx_a;
                    vidx_a++;
                end
            end else begin
                check("a_hold", got_v, last_a);
            end
        end
    end

    task automatic step_a(input bit e, input longint xs);
        bit cap;
        @(negedge clk);
        #1;
        cap = e && (ka % RA == 0);
        a_if.en = e;
        a_if.data_in = cap ? 16'(xs) : 16'($urandom);
        #1;
        check("a_data_clk", longint'(a_if.data_clk), longint'(cap));
        en_last_a = e;
        if (e) begin
            if (cap) xa.push_back(xs);
            last_a = model_a(ka);
            qa.push_back(last_a);
            ka++;
        end
    endtask

    task automatic reset_a();
        @(negedge clk);
        #2;
        a_if.en = 1'b0;
        arst_a_n = 1'b0;
        #1;
        check("a_rst_out", longint'($signed(a_if.data_out)), 0);
        check("a_rst_valid", longint'(a_if.data_valid), 0);
        qa.delete();
        xa.delete();
        ka = 0;
        last_a = 0;
        obs_last_a = 0;
        sum_a = 0;
        first_nz_a = -1;
        vidx_a = 0;
        en_last_a = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        arst_a_n = 1'b1;
        mon_a = 1'b1;
    endtask

    task automatic run_a();
        reset_a();
        for (int i = 0; i < 40; i++) step_a(1'b1, (ka == 0) ? 1 : 0);
        repeat (2) step_a(1'b0, 0);
        check("a_imp_sum", sum_a, 64);
        check("a_imp_first", first_nz_a, RA + NA - 1);

        reset_a();
        for (int i = 0; i < 600 && ka < 60; i++) step_a(1'($urandom_range(0, 1)), (ka == 0) ? 1 : 0);
        check("a_gap_count", ka, 60);
        repeat (2) step_a(1'b0, 0);
        check("a_gap_sum", sum_a, 64);
        check("a_gap_first", first_nz_a, RA + NA - 1);

        reset_a();
        for (int i = 0; i < 60; i++) step_a(1'b1, 100);
        check("a_dc_settle", obs_last_a, 1600);
        reset_a();
        for (int i = 0; i < 48; i++) step_a(1'b1, -32768);
        repeat (2) step_a(1'b0, 0);
        check("a_wrap_settle", obs_last_a, -524288);

        for (int i = 0; i < 9; i++) step_a(1'b1, 77);
        reset_a();
        for (int i = 0; i < 12; i++) step_a(1'b1, (ka == 0) ? 5 : 0);
        repeat (2) step_a(1'b0, 0);
        check("a_sb_drain", qa.size(), 0);
    endtask

    // ---------------- default config state and model ----------------
    longint hb   [LB];
    longint preb [2*RB];
    longint xb [$];
    longint qb [$];
    int     kb = 0;
    longint last_b = 0;
    bit     en_last_b = 1'b0;
    bit     mon_b = 1'b0;

    function automatic void build_hb();
        preb[0] = 0;
        for (int i = 0; i < 2 * RB - 1; i++) begin
            preb[i+1] = preb[i] + ((i < RB) ? i + 1 : 2 * RB - 1 - i);
        end
        for (int n = 0; n < LB; n++) begin
            int lo, hi;
            lo = (n - RB + 1 > 0) ? n - RB + 1 : 0;
            hi = (n < 2 * RB - 2) ? n : 2 * RB - 2;
            hb[n] = preb[hi+1] - preb[lo];
        end
    endfunction

    function automatic longint model_b(input int k);
        longint acc;
        logic [63:0] t;
        logic signed [11:0] s;
        acc = 0;
        for (int j = 0; j < xb.size(); j++) begin
            int idx;
            idx = k - (j * RB + RB + NB - 1);
            if (idx >= 0 && idx < LB) acc += xb[j] * hb[idx];
        end
        t = acc;
        s = t[39:28];
        return longint'(s);
    endfunction

    function automatic longint sine_b(input int j);
        real r;
        r = 2047.0 * $sin(2.0 * 3.141592653589793 * real'(j) / 64.0);
        return longint'($rtoi(r + ((r < 0.0) ? -0.5 : 0.5)));
    endfunction

    always @(negedge clk) begin
        if (mon_b && arst_b_n) begin
            longint got_v;
            got_v = longint'($signed(b_if.data_out));
            check("b_valid", longint'(b_if.data_valid), longint'(en_last_b));
            if (en_last_b) begin
                if (qb.size() == 0) check("b_sb_depth", qb.size(), 1);
                else check("b_out", got_v, qb.pop_front());
            end else begin
                check("b_hold", got_v, last_b);
            end
        end
    end

    task automatic step_b(input bit e, input longint xs);
        bit cap;
        @(negedge clk);
        #1;
        cap = e && (kb % RB == 0);
        b_if.en = e;
        b_if.data_in = cap ? 16'(xs) : 16'($urandom);
        #1;
        if (cap) check("b_data_clk", longint'(b_if.data_clk), 1);
        en_last_b = e;
        if (e) begin
            if (cap) xb.push_back(xs);
            last_b = model_b(kb);
            qb.push_back(last_b);
            kb++;
        end
    endtask

    task automatic run_b();
        @(negedge clk);
        #2;
        arst_b_n = 1'b0;
        #1;
        check("b_rst_out", longint'($signed(b_if.data_out)), 0);
        check("b_rst_valid", longint'(b_if.data_valid), 0);
        repeat (2) @(posedge clk);
        #3;
        arst_b_n = 1'b1;
        mon_b = 1'b1;
        for (int j = 0; j < B_SAMPLES; j++) begin
            for (int p = 0; p < RB; p++) step_b(1'b1, sine_b(j));
        end
        repeat (2) step_b(1'b0, 0);
        check("b_sb_drain", qb.size(), 0);
        check("b_no_x", longint'($isunknown(b_if.data_out) | $isunknown(b_if.data_valid)), 0);
    endtask

    initial begin
        a_if.en = 1'b0;
        a_if.data_in = '0;
        b_if.en = 1'b0;
        b_if.data_in = '0;
        build_hb();
        fork
            run_a();
            run_b();
        join
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
